ne_addrgen_multilyr: RTL and testbench

- Parametrised successor to the two-layer SISO address-generator FSM of the layered LDPC decoder.
- Sequences row addresses, L/E memory reads and RCU enables over NLAYERS layers per iteration, with a pipeline-drain wait after each layer.
- Iteration cap is set at run time; optional parity-based early termination.
- Sits between the load/unload FSM (start, loaden) and the Lmem/Emem/RCU array.

---
 rtl/ne_addrgen_pkg.sv | 20 ++
 rtl/ne_rowmask.sv | 19 +
 rtl/ne_addrgen_multilyr.sv | 194 +++++++++++++++++++
 tb/tb_ne_addrgen_multilyr.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ne_addrgen_pkg.sv
// Shared types and helpers for the multi-layer LDPC SISO address generator.
package ne_addrgen_pkg;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_SWEEP = 2'd1,
    S_WAIT  = 2'd2
  } ag_state_e;

  localparam int ROWWIDTH_D       = 5;
  localparam int LYRWIDTH_D       = 1;
  localparam int PIPECOUNTWIDTH_D = 4;
  localparam int ITRWIDTH_D       = 4;

  // Number of RCUs still carrying valid rows at the final address of a layer.
  function automatic int p_last(input int z, input int p, input int rowdepth);
    return z - p * (rowdepth - 1);
  endfunction

endpackage

// File: rtl/ne_rowmask.sv
// Per-RCU row-valid mask: all lanes follow rd, except lanes >= P_LAST at the last row.
module ne_rowmask #(
  parameter int P      = 26,
  parameter int P_LAST = 17
) (
  input  logic         rd,
  input  logic         last_row,
  output logic [P-1:0] mask
);

  for (genvar i = 0; i < P; i++) begin : g_lane
    if (i < P_LAST) begin : g_full
      assign mask[i] = rd;
    end else begin : g_part
      assign mask[i] = rd & ~last_row;
    end
  end

endmodule

// File: rtl/ne_addrgen_multilyr.sv
// Layered LDPC SISO address generator over NLAYERS layers per iteration.
// Define AG_EARLY_TERM_EN to stop on parity_ok at the end of each iteration.
module ne_addrgen_multilyr
  import ne_addrgen_pkg::*;
#(
  parameter int Z              = 511,
  parameter int P              = 26,
  parameter int ROWDEPTH       = 20,
  parameter int P_LAST         = p_last(Z, P, ROWDEPTH),
  parameter int NLAYERS        = 2,
  parameter int PIPESTAGES     = 9,
  parameter int MAXITRS        = 10,
  parameter int ROWWIDTH       = ROWWIDTH_D,
  parameter int LYRWIDTH       = LYRWIDTH_D,
  parameter int PIPECOUNTWIDTH = PIPECOUNTWIDTH_D,
  parameter int ITRWIDTH       = ITRWIDTH_D
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                loaden,
  input  logic                start,
  input  logic [ITRWIDTH-1:0] max_itr,
  input  logic                parity_ok,
  output logic                SISOready,
  output logic                busy,
  output logic                firstprocessing_indicate,
  output logic [LYRWIDTH-1:0] LYRindex,
  output logic [ROWWIDTH-1:0] rowaddress,
  output logic                rd_L,
  output logic [P-1:0]        rd_E,
  output logic [P-1:0]        rcu_en,
  output logic [ITRWIDTH-1:0] itr_out,
  output logic                et_flag
);

  localparam logic [ROWWIDTH-1:0]       ROW_LAST  = ROWWIDTH'(ROWDEPTH - 1);
  localparam logic [LYRWIDTH-1:0]       LYR_LAST  = LYRWIDTH'(NLAYERS - 1);
  localparam logic [PIPECOUNTWIDTH-1:0] PIPE_LAST = PIPECOUNTWIDTH'(PIPESTAGES - 1);

  ag_state_e                 state, state_n;
  logic [ROWWIDTH-1:0]       count, count_n;
  logic [LYRWIDTH-1:0]       lyr, lyr_n;
  logic [PIPECOUNTWIDTH-1:0] pcnt, pcnt_n;
  logic [ITRWIDTH-1:0]       itr, itr_n;
  logic [ITRWIDTH-1:0]       eff_max, eff_max_n;
  logic                      rd, rd_n;
  logic                      sready, sready_n;
  logic                      et, et_n;
  logic                      early_term;
  logic [ITRWIDTH-1:0]       cap;
  logic                      more_itrs;
  logic                      last_row;
  logic [P-1:0]              mask;

`ifdef AG_EARLY_TERM_EN
  assign early_term = parity_ok;
`else
  logic unused_parity_ok;
  assign unused_parity_ok = parity_ok;
  assign early_term       = 1'b0;
`endif

  // Zero or out-of-range caps fall back to the hard ceiling.
  assign cap = (max_itr == '0 || int'(max_itr) > MAXITRS) ? ITRWIDTH'(MAXITRS) : max_itr;
  assign more_itrs = ({1'b0, itr} + 1'b1) < {1'b0, eff_max};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_INIT;
      count   <= '0;
      lyr     <= '0;
      pcnt    <= '0;
      itr     <= '0;
      eff_max <= '0;
      rd      <= 1'b0;
      sready  <= 1'b0;
      et      <= 1'b0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      lyr     <= lyr_n;
      pcnt    <= pcnt_n;
      itr     <= itr_n;
      eff_max <= eff_max_n;
      rd      <= rd_n;
      sready  <= sready_n;
      et      <= et_n;
    end
  end

  always_comb begin
    state_n   = state;
    count_n   = count;
    lyr_n     = lyr;
    pcnt_n    = pcnt;
    itr_n     = itr;
    eff_max_n = eff_max;
    rd_n      = rd;
    sready_n  = sready;
    et_n      = et;
    if (loaden) begin
      state_n   = S_INIT;
      count_n   = '0;
      lyr_n     = '0;
      pcnt_n    = '0;
      itr_n     = '0;
      eff_max_n = '0;
      rd_n      = 1'b0;
      sready_n  = 1'b0;
      et_n      = 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          if (start) begin
            state_n   = S_SWEEP;
            count_n   = '0;
            lyr_n     = '0;
            pcnt_n    = '0;
            itr_n     = '0;
            eff_max_n = cap;
            rd_n      = 1'b1;
            sready_n  = 1'b0;
            et_n      = 1'b0;
          end
        end
        S_SWEEP: begin
          rd_n = 1'b1;
          if (count == ROW_LAST) begin
            state_n = S_WAIT;
            rd_n    = 1'b0;
            pcnt_n  = '0;
          end else begin
            count_n = count + 1'b1;
          end
        end
        S_WAIT: begin
          rd_n = 1'b0;
          if (pcnt == PIPE_LAST) begin
            if (lyr != LYR_LAST) begin
              state_n = S_SWEEP;
              lyr_n   = lyr + 1'b1;
              count_n = '0;
              rd_n    = 1'b1;
            end else if (more_itrs && !early_term) begin
              state_n = S_SWEEP;
              itr_n   = itr + 1'b1;
              lyr_n   = '0;
              count_n = '0;
              rd_n    = 1'b1;
            end else begin
              state_n  = S_INIT;
              sready_n = 1'b1;
              et_n     = early_term;
            end
          end else begin
            pcnt_n = pcnt + 1'b1;
          end
        end
        default: begin
          state_n   = S_INIT;
          count_n   = '0;
          lyr_n     = '0;
          pcnt_n    = '0;
          itr_n     = '0;
          eff_max_n = '0;
          rd_n      = 1'b0;
          sready_n  = 1'b0;
          et_n      = 1'b0;
        end
      endcase
    end
  end

  assign last_row = (count == ROW_LAST);

  ne_rowmask #(.P(P), .P_LAST(P_LAST)) u_rowmask (
    .rd       (rd),
    .last_row (last_row),
    .mask     (mask)
  );

  assign busy                     = (state != S_INIT);
  assign firstprocessing_indicate = busy & (itr == '0) & (lyr == '0);
  assign LYRindex                 = lyr;
  assign rowaddress               = count;
  assign rd_L                     = rd;
  assign rcu_en                   = mask;
  // First iteration has no extrinsic history yet, so E memory stays idle.
  assign rd_E                     = (itr == '0) ? '0 : mask;
  assign itr_out                  = itr;
  assign SISOready                = sready;
  assign et_flag                  = et;

endmodule

// File: tb/tb_ne_addrgen_multilyr.sv
// Bench for ne_addrgen_multilyr: default and 4-layer instances against a timeline model.
module tb_ne_addrgen_multilyr;

  localparam int RD   = 20;
  localparam int PS   = 9;
  localparam int LAY  = RD + PS;
  localparam int MAXI = 10;
  localparam logic [25:0] FULLM = 26'h3FFFFFF;
  localparam logic [25:0] LASTM = 26'h001FFFF;
`ifdef AG_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic clk = 1'b0;
  logic clk_en = 1'b1;
  logic rst = 1'b1;
  logic loaden = 1'b0;
  logic start = 1'b0;
  logic [3:0] max_itr = 4'd0;
  logic parity_ok = 1'b0;

  logic [1:0]  busy_v, rdL_v, fpi_v, sr_v, et_v;
  logic [4:0]  row_v [2];
  logic [1:0]  lyr_v [2];
  logic [3:0]  itr_v [2];
  logic [25:0] rdE_v [2];
  logic [25:0] rcu_v [2];
  logic [0:0]  lyr0;
  logic [1:0]  lyr4;

  assign lyr_v[0] = {1'b0, lyr0};
  assign lyr_v[1] = lyr4;

  always #5 if (clk_en) clk = ~clk;

  ne_addrgen_multilyr dut (
    .clk(clk), .rst(rst), .loaden(loaden), .start(start), .max_itr(max_itr),
    .parity_ok(parity_ok), .SISOready(sr_v[0]), .busy(busy_v[0]),
    .firstprocessing_indicate(fpi_v[0]), .LYRindex(lyr0), .rowaddress(row_v[0]),
    .rd_L(rdL_v[0]), .rd_E(rdE_v[0]), .rcu_en(rcu_v[0]), .itr_out(itr_v[0]),
    .et_flag(et_v[0])
  );

  ne_addrgen_multilyr #(.NLAYERS(4), .LYRWIDTH(2)) dut4 (
    .clk(clk), .rst(rst), .loaden(loaden), .start(start), .max_itr(max_itr),
    .parity_ok(parity_ok), .SISOready(sr_v[1]), .busy(busy_v[1]),
    .firstprocessing_indicate(fpi_v[1]), .LYRindex(lyr4), .rowaddress(row_v[1]),
    .rd_L(rdL_v[1]), .rd_E(rdE_v[1]), .rcu_en(rcu_v[1]), .itr_out(itr_v[1]),
    .et_flag(et_v[1])
  );

  int nchk = 0;
  int npass = 0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    nchk++;
    if (a === e) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
  endtask

  // Model: one decode is a timeline t of edges since the start edge.
  int NLV [2] = '{2, 4};
  int act [2] = '{0, 0};
  int t   [2] = '{0, 0};
  int its [2] = '{0, 0};
  int sr  [2] = '{0, 0};
  int et  [2] = '{0, 0};
  int fin [2] = '{0, 0};
  int pd  [2] = '{0, 0};

  task automatic mstep(input int k);
    int itl, cur;
    itl = NLV[k] * LAY;
    if (!rst || loaden) begin
      act[k] = 0; t[k] = 0; sr[k] = 0; et[k] = 0; fin[k] = 0; pd[k] = 0;
    end else if (act[k] == 0) begin
      if (start) begin
        act[k] = 1; t[k] = 0; sr[k] = 0; et[k] = 0; pd[k] = 0;
        its[k] = (max_itr == 0 || int'(max_itr) > MAXI) ? MAXI : int'(max_itr);
      end
    end else if (t[k] % itl == itl - 1) begin
      cur = t[k] / itl;
      if ((ET && parity_ok) || cur == its[k] - 1) begin
        act[k] = 0; sr[k] = 1; et[k] = int'(ET && parity_ok); fin[k] = cur; pd[k] = 1;
      end else t[k]++;
    end else t[k]++;
  endtask

  always @(posedge clk or negedge rst) begin
    for (int k = 0; k < 2; k++) mstep(k);
  end

  task automatic cmp(input int k);
    int itl, e_itr, e_lyr, pos, e_row;
    bit e_rd, e_busy, e_fpi;
    logic [25:0] e_mask, e_rde;
    string p;
    p = (k == 0) ? "d2" : "d4";
    itl = NLV[k] * LAY;
    if (act[k] != 0) begin
      e_busy = 1'b1;
      e_itr  = t[k] / itl;
      e_lyr  = (t[k] % itl) / LAY;
      pos    = t[k] % LAY;
      e_rd   = (pos < RD);
      e_row  = e_rd ? pos : RD - 1;
      e_mask = !e_rd ? 26'd0 : (e_row == RD - 1) ? LASTM : FULLM;
      e_rde  = (e_itr == 0) ? 26'd0 : e_mask;
      e_fpi  = (e_itr == 0 && e_lyr == 0);
    end else begin
      e_busy = 1'b0; e_rd = 1'b0; e_fpi = 1'b0;
      e_itr  = fin[k];
      e_row  = (pd[k] != 0) ? RD - 1 : 0;
      e_lyr  = (pd[k] != 0) ? NLV[k] - 1 : 0;
      e_mask = 26'd0; e_rde = 26'd0;
    end
    chk({p, ".busy"},  64'(busy_v[k]), 64'(e_busy));
    chk({p, ".rd_L"},  64'(rdL_v[k]),  64'(e_rd));
    chk({p, ".row"},   64'(row_v[k]),  64'(e_row));
    chk({p, ".lyr"},   64'(lyr_v[k]),  64'(e_lyr));
    chk({p, ".itr"},   64'(itr_v[k]),  64'(e_itr));
    chk({p, ".rcu_en"}, 64'(rcu_v[k]), 64'(e_mask));
    chk({p, ".rd_E"},  64'(rdE_v[k]),  64'(e_rde));
    chk({p, ".fpi"},   64'(fpi_v[k]),  64'(e_fpi));
    chk({p, ".ready"}, 64'(sr_v[k]),   64'(sr[k]));
    chk({p, ".et"},    64'(et_v[k]),   64'(et[k]));
  endtask

  always @(negedge clk) if (rst) for (int k = 0; k < 2; k++) cmp(k);

  task automatic chk_zero(input int k, input string nm);
    chk({nm, ".outs"},
        {busy_v[k], rdL_v[k], row_v[k], lyr_v[k], itr_v[k], fpi_v[k], sr_v[k], et_v[k]}, 64'd0);
    chk({nm, ".masks"}, {rcu_v[k], rdE_v[k]}, 64'd0);
  endtask

  // Run one decode; returns edges from the start edge to SISOready on each instance.
  int rdcnt;
  task automatic run(input int mi, input int pulse_at, input int par_at, input bit lit,
                     output int n0, output int n4);
    max_itr = 4'(mi);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n0 = -1; n4 = -1; rdcnt = 0;
    for (int n = 1; n <= 2500 && (n0 < 0 || n4 < 0); n++) begin
      @(posedge clk); #1;
      start = (n == pulse_at);
      if (n == par_at) parity_ok = 1'b1;
      if (n0 < 0 && sr_v[0]) n0 = n;
      if (n4 < 0 && sr_v[1]) n4 = n;
      if (lit) begin
        if (n <= 29 && rdL_v[0]) rdcnt++;
        if (n == 19) chk("lit.row19", {row_v[0], rcu_v[0], rdE_v[0]}, {5'd19, LASTM, 26'd0});
        if (n == 20) chk("lit.wait_rd", rdL_v[0], 1'b0);
        if (n == 29) chk("lit.lyr1", {lyr0, rdL_v[0], fpi_v[0]}, 3'b110);
        if (n == 63) chk("lit.rdE_full", rdE_v[0], FULLM);
        if (n == 77) chk("lit.rdE_last", rdE_v[0], LASTM);
        if (n == 87) chk("lit.d4_lyr3", lyr4, 2'd3);
        if (n == 116) chk("lit.d4_itr1", {lyr4, itr_v[1]}, {2'd0, 4'd1});
      end
    end
  endtask

  initial begin
    int n0, n4;
    #2 rst = 1'b0;
    #1 chk_zero(0, "rst_d2"); chk_zero(1, "rst_d4");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    run(0, -1, -1, 1'b1, n0, n4);
    chk("full.edges_d2", n0, 580);
    chk("full.edges_d4", n4, 1160);
    chk("full.rd_cycles", rdcnt, 20);
    chk("full.itr_d2", itr_v[0], 4'd9);
    chk("full.itr_d4", itr_v[1], 4'd9);
    chk("full.ready_et", {sr_v[0], et_v[0]}, 2'b10);

    run(3, 50, -1, 1'b0, n0, n4);
    chk("cap3.edges_d2", n0, 174);
    chk("cap3.edges_d4", n4, 348);
    chk("cap3.itr_d2", itr_v[0], 4'd2);

    run(0, -1, 60, 1'b0, n0, n4);
`ifdef AG_EARLY_TERM_EN
    chk("et.edges", n0, 116);
    chk("et.flag_itr", {et_v[0], itr_v[0]}, {1'b1, 4'd1});
`else
    chk("et.edges", n0, 580);
    chk("et.flag_itr", {et_v[0], itr_v[0]}, {1'b0, 4'd9});
`endif
    parity_ok = 1'b0;

    max_itr = 4'd0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (50) @(posedge clk);
    #1 chk("lden.in_wait", {busy_v[0], rdL_v[0], lyr0}, 3'b101);
    loaden = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    chk_zero(0, "lden_d2"); chk_zero(1, "lden_d4");
    loaden = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("lden.idle", busy_v, 2'b00);

    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); clk_en = 1'b0;
    #2 chk("rstmid.busy", busy_v, 2'b11);
    rst = 1'b0;
    #1 chk_zero(0, "rstmid_d2"); chk_zero(1, "rstmid_d4");
    #2 rst = 1'b1;
    #3 clk_en = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("rstmid.idle", {busy_v, sr_v}, 4'b0000);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
